fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
- Write-side pointer and flag generator for the asynchronous FIFO.
- Sits directly upstream of the dual-clock FIFO storage array. It drives that array's binary write address, its full qualifier, and the Gray write pointer that is sent to the read domain.
- Synchronises the read domain's Gray read pointer into the write clock domain. From it, derives full, almost_full, fill level and a sticky overflow error.

Parameters:
- DEPTH, 8: FIFO entries. Must equal 2**PTR_WIDTH.
- PTR_WIDTH, 3: address bits. Pointers carry PTR_WIDTH+1 bits, including the wrap bit.
- AF_LEVEL, 6: almost_full threshold in entries. Legal range is 1..DEPTH.

Ports:
- wclock  input  1  write-domain clock. All logic is on the rising edge.
- wrst_n  input  1  reset; synchronous, active-low.
- w_en  input  1  write request from the producer.
- g_rptr  input  PTR_WIDTH+1  Gray read pointer from the read domain. Asynchronous to wclock.
- bin_wptr  output  PTR_WIDTH+1  binary write pointer. The low PTR_WIDTH bits are the storage write address.
- g_wptr  output  PTR_WIDTH+1  Gray write pointer, registered. Sent to the read-side synchroniser.
- full  output  1  FIFO holds DEPTH entries.
- almost_full  output  1  fill level is at least AF_LEVEL.
- wr_count  output  PTR_WIDTH+1  fill level as seen by the write side, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset: on a wclock edge with wrst_n=0, all of the following clear to 0:
  - bin_wptr, g_wptr, full, almost_full, wr_count, overflow;
  - both synchroniser stages.
  - Reset mid-operation discards all state on that edge. No write is accepted on the reset edge.
- Write acceptance: wr_ok = w_en & !full, evaluated on the current registered full.
- Next pointer: bin_next = bin_wptr + wr_ok, computed modulo 2**(PTR_WIDTH+1).
  - Wrap is natural roll-over of the extra bit: 4'b1111 goes to 4'b0000.
- Pointer registers: on each edge, bin_wptr <= bin_next and g_wptr <= bin_next ^ (bin_next >> 1).
  - g_wptr changes by exactly one bit per accepted write. It never glitches, because it is driven from a flop.
- The storage array writes at bin_wptr (pre-increment) on the same edge that the pointer advances.
- Synchroniser: two flop stages, rq1 <= g_rptr then rq2 <= rq1. No logic sits between the stages.
- Read pointer in binary: rbin = Gray-to-binary of rq2, computed as an XOR-prefix from the MSB down.
- Flag registers, updated every edge:
  - full <= (bin_next ^ (bin_next>>1)) == {~rq2[PTR_WIDTH:PTR_WIDTH-1], rq2[PTR_WIDTH-2:0]}.
  - wr_count <= bin_next - rbin, taken in PTR_WIDTH+1 bits. The result is always 0..DEPTH.
  - almost_full <= (bin_next - rbin) >= AF_LEVEL.
  - overflow <= overflow | (w_en & full). It clears only on reset.
- Consistency: full == (wr_count == DEPTH) on every cycle after reset.
- Latency:
  - An accepted write is reflected in bin_wptr, g_wptr, wr_count and full on the same edge. Flags are therefore pessimistic-correct for the next request.
  - A change on g_rptr affects full, almost_full and wr_count on the 3rd wclock edge after it: rq1, then rq2, then the flags.
- Simultaneous write and read-pointer advance: the write is counted immediately; the read is seen after the 2-edge synchroniser delay. Full may stay high for up to 3 extra cycles. This is conservative and never lets a write overrun.
- Write while full: the write is ignored, the pointer holds, and overflow sets on that edge.
- Width rule: all pointer arithmetic is PTR_WIDTH+1 bits unsigned. No saturation is needed.

Test Plan:
- Reset with wrst_n=0 held for 2 edges, w_en=1, g_rptr=4'b0101 -> all outputs 0 throughout; after release, rq2 settles on the 2nd edge.
- g_rptr=0, w_en=1 for 8 cycles:
  - bin_wptr steps 0..8 and g_wptr follows 0,1,3,2,6,7,5,4,12;
  - almost_full rises on the edge of the 6th write;
  - full=1 and wr_count=8 after the 8th write.
- Continue w_en=1 for a 9th cycle -> bin_wptr stays 8, overflow=1. overflow stays 1 after w_en drops, until reset.
- From full, drive g_rptr=4'b0001 (read pointer 1) -> full=0 and wr_count=7 exactly 3 edges later; almost_full stays 1.
- Wrap: advance both pointers past 15 in step, with g_rptr tracking bin 14 and the write pointer at 15. Write 1 -> bin_wptr=0, g_wptr=0, wr_count=2, with no false full.
- Reset asserted mid-burst at wr_count=5 -> the next edge gives all outputs 0, and the write presented on that edge is dropped.

Source files
------------

// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of the async FIFO: producer request, the read domain's
// Gray pointer, and everything the write-pointer block drives back out.
interface fifo_wptr_full_if #(
    parameter int PTR_WIDTH = 3
);
    logic               w_en;
    logic [PTR_WIDTH:0] g_rptr;
    logic [PTR_WIDTH:0] bin_wptr;
    logic [PTR_WIDTH:0] g_wptr;
    logic               full;
    logic               almost_full;
    logic [PTR_WIDTH:0] wr_count;
    logic               overflow;

    // Producer / environment side
    modport master (
        output w_en, g_rptr,
        input  bin_wptr, g_wptr, full, almost_full, wr_count, overflow
    );

    // Write-pointer block side
    modport slave (
        input  w_en, g_rptr,
        output bin_wptr, g_wptr, full, almost_full, wr_count, overflow
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag generator for the dual-clock FIFO.
// Advances the binary/Gray write pointers, synchronises the Gray read
// pointer into wclock and registers full, almost_full, fill level and a
// sticky overflow error.
module fifo_wptr_full #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3,
    parameter int AF_LEVEL  = 6
) (
    input  logic              wclock,
    input  logic              wrst_n,
    fifo_wptr_full_if.slave   bus
);
    localparam int PW = PTR_WIDTH + 1;

    // Keep the threshold inside its legal 1..DEPTH range.
    localparam int AF_CLAMP = (AF_LEVEL < 1) ? 1 :
                              (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_CLAMP);

    logic [PW-1:0] bin_wptr;
    logic [PW-1:0] g_wptr;
    logic [PW-1:0] wr_count;
    logic          full;
    logic          almost_full;
    logic          overflow;

    logic [PW-1:0] rq1;
    logic [PW-1:0] rq2;

    logic          wr_ok;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_match;
    logic [PW-1:0] count_next;

    // Next-pointer arithmetic, read-pointer decode and flag terms.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        rbin = '0;

        wr_ok     = bus.w_en & ~full;
        bin_next  = bin_wptr + {{(PW-1){1'b0}}, wr_ok};
        gray_next = bin_next ^ (bin_next >> 1);

        // Gray to binary: each bit is the XOR of all Gray bits at or above it.
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rq2 >> i);
        end

        // Full when the write pointer sits exactly one lap ahead of the read
        // pointer: in Gray that means the top two bits inverted.
        full_match = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
        count_next = bin_next - rbin;
    end

    // Two-flop synchroniser for the Gray read pointer.
    always_ff @(posedge wclock) begin
        // NOTE: reset is sampled on the clock edge only; wrst_n is not in the
        // sensitivity list, so a reset edge is an ordinary clocked update.
        if (!wrst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= bus.g_rptr;
            rq2 <= rq1;
        end
    end

    // Write pointers: binary for the storage address, Gray for the read side.
    always_ff @(posedge wclock) begin
        if (!wrst_n) begin
            bin_wptr <= '0;
            g_wptr   <= '0;
        end else begin
            bin_wptr <= bin_next;
            g_wptr   <= gray_next;
        end
    end

    // Flags use the post-write pointer so they are already valid for the
    // next request; overflow latches until reset.
    always_ff @(posedge wclock) begin
        if (!wrst_n) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            full        <= (gray_next == full_match);
            almost_full <= (count_next >= AF_THRESH);
            wr_count    <= count_next;
            overflow    <= overflow | (bus.w_en & full);
        end
    end

    assign bus.bin_wptr    = bin_wptr;
    assign bus.g_wptr      = g_wptr;
    assign bus.full        = full;
    assign bus.almost_full = almost_full;
    assign bus.wr_count    = wr_count;
    assign bus.overflow    = overflow;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: a count-based model checked every
// cycle, plus directed steps with hand-computed literal expectations.
module tb_fifo_wptr_full;
    localparam int PTR_WIDTH = 3;
    localparam int DEPTH     = 8;
    localparam int AF_LEVEL  = 6;
    localparam int MODN      = 16;

    logic wclock;
    logic wrst_n;

    fifo_wptr_full_if #(.PTR_WIDTH(PTR_WIDTH)) bus ();

    fifo_wptr_full #(
        .DEPTH    (DEPTH),
        .PTR_WIDTH(PTR_WIDTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .wclock(wclock),
        .wrst_n(wrst_n),
        .bus   (bus)
    );

    initial wclock = 1'b0;
    always #5 wclock = ~wclock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gray2bin(input logic [3:0] g);
        int b = 0;
        for (int i = 3; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
        end
        return b;
    endfunction

    function automatic int bin2gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Behavioural model: write count, synchronised read position, fill level.
    bit model_ok = 0;
    int m_wp, m_s1, m_s2, m_count;
    bit m_full, m_af, m_ovf;

    always @(posedge wclock) begin
        int seen_rp;
        if (!wrst_n) begin
            m_wp = 0; m_s1 = 0; m_s2 = 0; m_count = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
            model_ok = 1;
        end else begin
            seen_rp = m_s2;
            m_s2 = m_s1;
            m_s1 = gray2bin(bus.g_rptr);
            if (bus.w_en && m_full) m_ovf = 1;
            if (bus.w_en && !m_full) m_wp = (m_wp + 1) % MODN;
            m_count = (m_wp - seen_rp + MODN) % MODN;
            m_full  = (m_count == DEPTH);
            m_af    = (m_count >= AF_LEVEL);
        end
    end

    // Compare on the falling edge, well away from the active edge.
    always @(negedge wclock) begin
        if (model_ok) begin
            check("mdl_bin_wptr", bus.bin_wptr, m_wp);
            check("mdl_g_wptr", bus.g_wptr, bin2gray(m_wp));
            check("mdl_wr_count", bus.wr_count, m_count);
            check("mdl_full", bus.full, m_full);
            check("mdl_almost_full", bus.almost_full, m_af);
            check("mdl_overflow", bus.overflow, m_ovf);
            check("full_vs_count", bus.full, (bus.wr_count == 4'd8));
        end
    end

    task automatic do_cycle(input logic rst, input logic wen, input logic [3:0] gr);
        wrst_n     = rst;
        bus.w_en   = wen;
        bus.g_rptr = gr;
        @(posedge wclock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bin"}, bus.bin_wptr, 0);
        check({tag, "_gray"}, bus.g_wptr, 0);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_af"}, bus.almost_full, 0);
        check({tag, "_cnt"}, bus.wr_count, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
    endtask

    int gtab [8];
    logic [3:0] gr;

    initial begin
        gtab = '{1, 3, 2, 6, 7, 5, 4, 12};

        // Reset held two edges with a write pending and a nonzero read pointer.
        do_cycle(1'b0, 1'b1, 4'b0101);
        check_zero("rst1");
        do_cycle(1'b0, 1'b1, 4'b0101);
        check_zero("rst2");

        // Release and let the synchroniser see a zero read pointer.
        do_cycle(1'b1, 1'b0, 4'b0000);
        do_cycle(1'b1, 1'b0, 4'b0000);
        check("idle_cnt", bus.wr_count, 0);

        // Eight writes into an empty FIFO.
        for (int k = 1; k <= 8; k++) begin
            do_cycle(1'b1, 1'b1, 4'b0000);
            check("fill_bin", bus.bin_wptr, k);
            check("fill_gray", bus.g_wptr, gtab[k-1]);
            check("fill_af", bus.almost_full, (k >= 6));
        end
        check("fill_full", bus.full, 1);
        check("fill_cnt", bus.wr_count, 8);
        check("fill_ovf", bus.overflow, 0);

        // Ninth write is refused and flags overflow.
        do_cycle(1'b1, 1'b1, 4'b0000);
        check("ovf_bin", bus.bin_wptr, 8);
        check("ovf_set", bus.overflow, 1);
        do_cycle(1'b1, 1'b0, 4'b0000);
        check("ovf_sticky", bus.overflow, 1);

        // Read pointer moves to 1: flags change on the third edge.
        do_cycle(1'b1, 1'b0, 4'b0001);
        check("rd_e1_full", bus.full, 1);
        do_cycle(1'b1, 1'b0, 4'b0001);
        check("rd_e2_full", bus.full, 1);
        do_cycle(1'b1, 1'b0, 4'b0001);
        check("rd_e3_full", bus.full, 0);
        check("rd_e3_cnt", bus.wr_count, 7);
        check("rd_e3_af", bus.almost_full, 1);

        // Drain to read pointer 8 (Gray 12), then write up to 14.
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0, 4'd12);
        check("drain_cnt", bus.wr_count, 0);
        for (int k = 0; k < 6; k++) do_cycle(1'b1, 1'b1, 4'd12);
        check("w14_bin", bus.bin_wptr, 14);
        check("w14_af", bus.almost_full, 1);

        // Read pointer to 14 (Gray 9), write pointer to 15.
        gr = 4'd9;
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0, gr);
        do_cycle(1'b1, 1'b1, gr);
        check("w15_bin", bus.bin_wptr, 15);
        check("w15_cnt", bus.wr_count, 1);

        // Wrap past 15.
        do_cycle(1'b1, 1'b1, gr);
        check("wrap_bin", bus.bin_wptr, 0);
        check("wrap_gray", bus.g_wptr, 0);
        check("wrap_cnt", bus.wr_count, 2);
        check("wrap_full", bus.full, 0);

        // Build to five entries, then reset mid-burst.
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b1, gr);
        check("burst_cnt", bus.wr_count, 5);
        do_cycle(1'b0, 1'b1, 4'b0000);
        check_zero("midrst");

        // Life after reset.
        do_cycle(1'b1, 1'b1, 4'b0000);
        do_cycle(1'b1, 1'b1, 4'b0000);
        check("post_bin", bus.bin_wptr, 2);
        check("post_gray", bus.g_wptr, 3);
        do_cycle(1'b1, 1'b0, 4'b0000);

        @(negedge wclock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
